uart_rx: RTL and testbench
==========================

# uart_rx

Receive-side UART stage sitting directly downstream of the baud clock generator. It consumes the generator's RX divisor (`rx_baud_divisor`) and runs its own mid-bit sampling counter. It deserialises an 8N1/8E1/8O1 frame from the asynchronous `rxd` pin into a one-entry holding register with a valid/ready handshake. It reports `rx_idle` back to the generator so the divisor is only swapped between frames.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5..8).
- `PARITY_EN`, default 0: 1 means a parity bit follows the data.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even. Ignored when `PARITY_EN=0`.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input, idle high.
- `baud_divisor`  in  16  clocks per bit, taken from `rx_baud_divisor`.
- `rx_data`  out  DATA_BITS  received word, LSB first on the line.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: frame completed while `rx_valid` was still high.
- `rx_idle`  out  1  high while the FSM is in IDLE.

## Operation
- **Input sync**: `rxd` passes through 2 flip-flops (reset value 1) to give `rxd_s`. Start detect is `rxd_s` 1→0, using a registered previous value.
- **Divisor latch**: `baud_divisor` is latched into `div_q` on start detect and held for the whole frame. Values below 2 are clamped to 2.
- **Bit counter**: 16 bits. It loads `(div_q>>1)-1` for the half-bit and `div_q-1` for each full bit. It decrements every cycle, and a sample is taken when it equals 0.
- **FSM states**:
  - IDLE → START on start detect, if `armed` is set.
  - START: sample `rxd_s`. If 1 it was a false start → IDLE, no flags raised. If 0 → DATA.
  - DATA: shift in `DATA_BITS` samples, LSB first. Then go to PARITY if `PARITY_EN`, otherwise STOP.
  - PARITY: compare the sample against the XOR of the data bits, with odd/even parity applied. A mismatch latches an internal error.
  - STOP: sample, then return to IDLE the same cycle. This allows back-to-back frames with no gap.
- **Stop handling**:
  - Stop sample 0 → `frame_err` pulses and `armed` clears. `armed` sets again only after `rxd_s` is seen high, so a break condition cannot retrigger reception.
  - The word is still delivered to the holding register on a framing or parity error.
- **Holding register**: loaded at the stop sample when `rx_valid=0`.
  - If `rx_valid=1` at the stop sample, the new word is dropped, `overrun` pulses, and the old word is kept.
  - If `rx_ready` is high in the same cycle as a stop-sample load, the accept clears the old word and the new word loads; `rx_valid` stays 1.
- **Reset values**:
  - Outputs: `rx_valid=0`, `rx_data=0`, all error pulses 0, `rx_idle=1` (state IDLE).
  - Internals: `armed=1`, synchronizers at 1, `div_q=5208`.
- **Reset mid-frame**: the partial word is discarded and no flags are raised.

## Timing
- Synchronizer latency is 2 cycles from a pin change to `rxd_s`.
- Let E be the cycle in which start detect is registered:
  - Start is sampled at E+`div_q/2` (integer division).
  - Data bit k (0-based) is sampled at E+`div_q/2`+(k+1)·`div_q`.
  - Parity, if enabled, follows one `div_q` after the last data bit.
  - Stop follows one `div_q` after that.
- `rx_valid`, `frame_err`, `parity_err` and `overrun` assert in the cycle after the stop sample.
- `rx_idle` goes low in the cycle after E and goes high in the cycle after the stop sample.
- The accept (`rx_valid & rx_ready`) clears `rx_valid` on the next edge.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - `DEFAULT_DIVISOR = 16'd5208`.
  - `MIN_DIVISOR = 16'd2`.
- One sub-module, `uart_sync2`: a 2-flip-flop synchronizer with a reset value parameter. The TX side and the baud generator's idle synchronizers will reuse it.

## Test plan
- **Basic receive**: `div=16`, 8N1, send 0xA5 with `rx_ready=0`.
  - Start sampled at E+8; `rx_valid` rises at E+153; `rx_data=0xA5`; `rx_idle` low from E+1 to E+152.
- **Overrun**: send 0x3C then 0xC3 back-to-back with `rx_ready` held 0.
  - `rx_data` stays 0x3C; `overrun` pulses once at the end of the second frame.
  - Assert `rx_ready` → `rx_valid` drops the next cycle.
- **False start**: drive a 3-cycle low glitch on `rxd` with `div=16`.
  - FSM returns to IDLE at E+8; no `rx_valid` and no error flags.
- **Framing error and break**: send a stop bit of 0, then hold `rxd` low for 300 cycles.
  - `frame_err` pulses once and the word is delivered.
  - No new frame starts until `rxd` returns high and then falls again.
- **Parity**: `PARITY_EN=1`, `PARITY_ODD=0`.
  - Send 0x07 with parity bit 1 → no error.
  - Send 0x07 with parity bit 0 → `parity_err` pulse.
- **Divisor change and reset**:
  - Change `baud_divisor` from 16 to 8 mid-frame → the current frame still uses 16; the next frame uses 8.
  - Assert `rst` mid-frame → all outputs return to reset values the next cycle, with `rx_idle=1`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver frame-walk states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // 9600 baud from a 50 MHz system clock
    localparam logic [15:0] DEFAULT_DIVISOR = 16'd5208;

    // Smallest divisor that still leaves a non-zero full-bit reload
    localparam logic [15:0] MIN_DIVISOR = 16'd2;

    // Clamp a requested divisor into the range the bit counter can handle
    function automatic logic [15:0] clamp_divisor(input logic [15:0] div);
        return (div < MIN_DIVISOR) ? MIN_DIVISOR : div;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Holding-register handshake and error pulses from the UART receiver.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    // Receiver side: owns the word and the status pulses
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output overrun,
        input  rx_ready
    );

    // Consumer side: reads the word and accepts it
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module uart_sync2 #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two back-to-back flops; reset forces both to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of 8N1/8E1/8O1 frames into a
// one-entry holding register with a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] baud_divisor,
    output logic        rx_idle,
    uart_rx_if.master   bus
);

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    logic                 rxd_prev_q;
    logic                 start_det;
    logic                 bit_tick;
    logic                 stop_sample;
    logic                 par_exp;
    logic                 accept;
    logic [15:0]          div_in;

    rx_state_t            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          div_q, div_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 armed_q, armed_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign start_det = rxd_prev_q & ~rxd_s;
    assign bit_tick  = (cnt_q == 16'd0);
    assign div_in    = clamp_divisor(baud_divisor);
    // Expected line value of the parity bit for the shifted word
    assign par_exp   = (^shift_q) ^ PARITY_ODD;
    assign accept    = valid_q & bus.rx_ready;

    // Frame walker: divisor latch, bit timing, data shift and parity check
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        stop_sample = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = cnt_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start_det && armed_q) begin
                    state_d   = START;
                    div_d     = div_in;
                    // First sample lands half a bit in, at the centre of the start bit
                    cnt_d     = (div_in >> 1) - 16'd1;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    cnt_d   = div_q - 16'd1;
                    // Line back high at mid-start means a glitch, not a frame
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d   = div_q - 16'd1;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_d   = div_q - 16'd1;
                    state_d = STOP;
                    if (rxd_s != par_exp) begin
                        par_err_d = 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    // Straight back to IDLE so a following start edge is caught
                    stop_sample = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Break guard: a low stop bit disarms until the line is seen high again
    always_comb begin
        armed_d = armed_q;
        if (stop_sample && !rxd_s) begin
            armed_d = 1'b0;
        end else if (rxd_s) begin
            armed_d = 1'b1;
        end
    end

    // Holding register, accept handling and one-cycle status pulses
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~accept;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        ovr_d   = 1'b0;
        if (stop_sample) begin
            ferr_d = ~rxd_s;
            perr_d = par_err_q;
            // Word is delivered even with a framing or parity error
            if (!valid_d) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Frame-walker state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DEFAULT_DIVISOR;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            armed_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            armed_q    <= armed_d;
            rxd_prev_q <= rxd_s;
        end
    end

    // Output-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_idle        = (state_q == IDLE);
    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance checked every
// cycle against a sample-schedule model, plus literal timing/data checks.
module tb_uart_rx;

    localparam int HIST = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        ready;
    logic        rxd_n, rxd_p;
    logic        idle_n, idle_p;
    int          cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_if #(.DATA_BITS(8)) bus_n ();
    uart_rx_if #(.DATA_BITS(8)) bus_p ();

    assign bus_n.rx_ready = ready;
    assign bus_p.rx_ready = ready;

    uart_rx #(
        .DATA_BITS  (8),
        .PARITY_EN  (1'b0),
        .PARITY_ODD (1'b0)
    ) dut_n (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd_n),
        .baud_divisor (baud_div),
        .rx_idle      (idle_n),
        .bus          (bus_n)
    );

    uart_rx #(
        .DATA_BITS  (8),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut_p (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd_p),
        .baud_divisor (baud_div),
        .rx_idle      (idle_p),
        .bus          (bus_p)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // {idle, valid, data[7:0], frame_err, parity_err, overrun}
    logic [12:0] obs_n, obs_p;
    assign obs_n = {idle_n, bus_n.rx_valid, bus_n.rx_data,
                    bus_n.frame_err, bus_n.parity_err, bus_n.overrun};
    assign obs_p = {idle_p, bus_p.rx_valid, bus_p.rx_data,
                    bus_p.frame_err, bus_p.parity_err, bus_p.overrun};

    // ---------------- model state ----------------
    logic     hist [2][HIST];
    int       force_until = 2;
    bit       m_init = 1'b0;
    bit       m_busy [2];
    bit       m_armed [2];
    int       m_e [2];
    int       m_div [2];
    logic [7:0] m_word [2];
    bit       m_perr [2];
    bit       e_valid [2];
    bit       e_idle [2];
    bit       e_ferr [2];
    bit       e_perr [2];
    bit       e_ovr [2];
    logic [7:0] e_data [2];

    // ---------------- monitors ----------------
    int rise_cyc [2];
    int idle_fall [2];
    int idle_rise [2];
    int n_starts [2];
    int n_ferr [2];
    int n_perr [2];
    int n_ovr [2];
    bit prev_valid [2];
    bit prev_idle [2];

    // Synchronised line level in cycle t: the pin two cycles earlier,
    // forced high for two cycles following a reset.
    function automatic bit rxds(input int id, input int t);
        if (t <= force_until) return 1'b1;
        return hist[id][(t - 2) % HIST];
    endfunction

    // Advance the model through cycle cyc; sets expectations for cyc+1
    task automatic model_step(input int id);
        bit rs, rsp, nvalid, stop_zero;
        int off, slot, last;
        int pe;
        pe = (id == 1) ? 1 : 0;
        if (rst) begin
            e_valid[id] = 1'b0;
            e_data[id]  = 8'h00;
            e_idle[id]  = 1'b1;
            e_ferr[id]  = 1'b0;
            e_perr[id]  = 1'b0;
            e_ovr[id]   = 1'b0;
            m_busy[id]  = 1'b0;
            m_armed[id] = 1'b1;
            force_until = cyc + 2;
            return;
        end
        rs        = rxds(id, cyc);
        rsp       = rxds(id, cyc - 1);
        nvalid    = e_valid[id] && !ready;
        stop_zero = 1'b0;
        e_ferr[id] = 1'b0;
        e_perr[id] = 1'b0;
        e_ovr[id]  = 1'b0;
        if (!m_busy[id]) begin
            if (m_armed[id] && rsp && !rs) begin
                m_busy[id] = 1'b1;
                m_e[id]    = cyc;
                m_div[id]  = (baud_div < 16'd2) ? 2 : int'(baud_div);
                m_word[id] = 8'h00;
                m_perr[id] = 1'b0;
            end
        end else begin
            off  = cyc - m_e[id] - m_div[id] / 2;
            last = 9 + pe;
            if (off >= 0 && off % m_div[id] == 0) begin
                slot = off / m_div[id];
                if (slot == 0) begin
                    if (rs) m_busy[id] = 1'b0;
                end else if (slot <= 8) begin
                    m_word[id][slot-1] = rs;
                end else if (slot == last) begin
                    m_busy[id] = 1'b0;
                    stop_zero  = !rs;
                    e_ferr[id] = !rs;
                    e_perr[id] = m_perr[id];
                    if (e_valid[id] && !ready) begin
                        e_ovr[id] = 1'b1;
                    end else begin
                        e_data[id] = m_word[id];
                        nvalid     = 1'b1;
                    end
                end else begin
                    m_perr[id] = (rs != (^m_word[id]));
                end
            end
        end
        if (stop_zero) m_armed[id] = 1'b0;
        else if (rs) m_armed[id] = 1'b1;
        e_valid[id] = nvalid;
        e_idle[id]  = !m_busy[id];
    endtask

    // Per-cycle compare against the model, monitors, then model advance
    initial begin
        logic [12:0] act, expv;
        for (int i = 0; i < 2; i++) begin
            prev_valid[i] = 1'b0;
            prev_idle[i]  = 1'b1;
            rise_cyc[i] = -1; idle_fall[i] = -1; idle_rise[i] = -1;
            n_starts[i] = 0; n_ferr[i] = 0; n_perr[i] = 0; n_ovr[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int id = 0; id < 2; id++) begin
                act  = (id == 0) ? obs_n : obs_p;
                expv = {e_idle[id], e_valid[id], e_data[id],
                        e_ferr[id], e_perr[id], e_ovr[id]};
                if (m_init) begin
                    n_tests++;
                    if (act !== expv) begin
                        n_fail++;
                        $display("FAIL model_%0d cyc=%0d got=%h expected=%h", id, cyc, act, expv);
                    end
                end
                if (!prev_valid[id] && act[11]) rise_cyc[id] = cyc;
                if (prev_idle[id] && !act[12]) begin
                    idle_fall[id] = cyc;
                    n_starts[id]++;
                end
                if (!prev_idle[id] && act[12]) idle_rise[id] = cyc;
                n_ferr[id] += int'(act[2]);
                n_perr[id] += int'(act[1]);
                n_ovr[id]  += int'(act[0]);
                prev_valid[id] = act[11];
                prev_idle[id]  = act[12];
                hist[id][cyc % HIST] = (id == 0) ? rxd_n : rxd_p;
                model_step(id);
            end
            if (rst) m_init = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_pin(input int id, input logic v);
        if (id == 0) rxd_n = v;
        else rxd_p = v;
    endtask

    // Caller must be at posedge+2. e returns the start-detect cycle.
    task automatic send_frame(input int id, input logic [7:0] d, input bit pe,
                              input logic par, input logic stop, input int bitlen,
                              output int e);
        e = cyc + 2;
        set_pin(id, 1'b0);
        tick(bitlen);
        for (int i = 0; i < 8; i++) begin
            set_pin(id, d[i]);
            tick(bitlen);
        end
        if (pe) begin
            set_pin(id, par);
            tick(bitlen);
        end
        set_pin(id, stop);
        tick(bitlen);
    endtask

    task automatic accept_pulse();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d failed so far", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int e, e2, c0, cnt0, cnt1, cnt2;
        rst = 1'b1; baud_div = 16'd16; ready = 1'b0; rxd_n = 1'b1; rxd_p = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        tick(4);
        chk("reset_idle", int'(idle_n), 1);
        chk("reset_valid", int'(bus_n.rx_valid), 0);
        chk("reset_data", int'(bus_n.rx_data), 0);

        // Basic 8N1 receive of 0xA5
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 16, e);
        tick(4);
        chk("basic_idle_fall", idle_fall[0], e + 1);
        chk("basic_valid_rise", rise_cyc[0], e + 153);
        chk("basic_idle_rise", idle_rise[0], e + 153);
        chk("basic_data", int'(bus_n.rx_data), 'hA5);
        accept_pulse();
        chk("accept_clears", int'(bus_n.rx_valid), 0);

        // Overrun: two back-to-back frames, nobody accepting
        cnt0 = n_ovr[0];
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 16, e);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 16, e);
        tick(4);
        chk("overrun_data_kept", int'(bus_n.rx_data), 'h3C);
        chk("overrun_pulses", n_ovr[0], cnt0 + 1);
        chk("overrun_valid", int'(bus_n.rx_valid), 1);
        accept_pulse();
        chk("overrun_accept", int'(bus_n.rx_valid), 0);

        // False start: three-cycle glitch
        cnt0 = n_ferr[0] + n_perr[0] + n_ovr[0];
        e = cyc + 2;
        set_pin(0, 1'b0);
        tick(3);
        set_pin(0, 1'b1);
        tick(30);
        chk("false_idle_fall", idle_fall[0], e + 1);
        chk("false_idle_rise", idle_rise[0], e + 9);
        chk("false_no_valid", int'(bus_n.rx_valid), 0);
        chk("false_no_flags", n_ferr[0] + n_perr[0] + n_ovr[0], cnt0);

        // Framing error followed by a 300-cycle break
        cnt0 = n_ferr[0];
        cnt1 = n_starts[0];
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 16, e);
        tick(300);
        chk("frame_err_pulse", n_ferr[0], cnt0 + 1);
        chk("frame_err_data", int'(bus_n.rx_data), 'h5A);
        chk("frame_err_valid", int'(bus_n.rx_valid), 1);
        chk("break_no_restart", n_starts[0], cnt1 + 1);
        accept_pulse();
        set_pin(0, 1'b1);
        tick(20);
        send_frame(0, 8'h69, 1'b0, 1'b0, 1'b1, 16, e);
        tick(4);
        chk("after_break_data", int'(bus_n.rx_data), 'h69);
        chk("after_break_start", n_starts[0], cnt1 + 2);
        accept_pulse();

        // Even parity on the 8E1 instance
        cnt2 = n_perr[1];
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 16, e);
        tick(4);
        chk("parity_ok_flag", n_perr[1], cnt2);
        chk("parity_ok_data", int'(bus_p.rx_data), 'h07);
        chk("parity_ok_rise", rise_cyc[1], e + 169);
        accept_pulse();
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 16, e);
        tick(4);
        chk("parity_bad_flag", n_perr[1], cnt2 + 1);
        chk("parity_bad_data", int'(bus_p.rx_data), 'h07);
        accept_pulse();

        // Divisor change mid-frame applies only to the next frame
        fork
            send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1, 16, e);
            begin
                tick(40);
                baud_div = 16'd8;
            end
        join
        tick(4);
        chk("divchg_old_rise", rise_cyc[0], e + 153);
        chk("divchg_old_data", int'(bus_n.rx_data), 'h96);
        accept_pulse();
        send_frame(0, 8'h4B, 1'b0, 1'b0, 1'b1, 8, e2);
        tick(4);
        chk("divchg_new_rise", rise_cyc[0], e2 + 77);
        chk("divchg_new_data", int'(bus_n.rx_data), 'h4B);
        accept_pulse();

        // Divisor below the minimum is clamped to 2
        baud_div = 16'd1;
        send_frame(0, 8'hE1, 1'b0, 1'b0, 1'b1, 2, e);
        tick(4);
        chk("clamp_rise", rise_cyc[0], e + 20);
        chk("clamp_data", int'(bus_n.rx_data), 'hE1);
        baud_div = 16'd16;
        tick(4);

        // Reset in the middle of a frame with a word still pending
        chk("pre_reset_valid", int'(bus_n.rx_valid), 1);
        c0 = cyc;
        set_pin(0, 1'b0);
        tick(50);
        chk("midframe_busy", int'(idle_n), 0);
        rst = 1'b1;
        set_pin(0, 1'b1);
        tick(1);
        chk("rst_idle", int'(idle_n), 1);
        chk("rst_valid", int'(bus_n.rx_valid), 0);
        chk("rst_data", int'(bus_n.rx_data), 0);
        chk("rst_flags", int'({bus_n.frame_err, bus_n.parity_err, bus_n.overrun}), 0);
        rst = 1'b0;
        tick(40);
        chk("rst_no_word", int'(bus_n.rx_valid), 0);
        chk("rst_elapsed", cyc - c0, 91);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
